dp_pipe_ctrl: RTL and testbench
===============================

DP_PIPE_CTRL -- requirements
Module: dp_pipe_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 5, fixed datapath latency in cycles from issue to result (2..16).
REQ-002 SHALL have parameter DEPTH, default 8, result FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter DATA_W, default 32, result width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand set present on the datapath inputs this cycle.
REQ-007 SHALL have port in_mode  input  1  requested precision (1 = FP32, 0 = FP16).
REQ-008 SHALL have port in_ready  output  1  operand set accepted when high together with in_valid.
REQ-009 SHALL have port dp_mode  output  1  precision mode driven to the dot-product datapath.
REQ-010 SHALL have port dp_issue  output  1  marks the accepted operand set entering the datapath.
REQ-011 SHALL have port dp_result  input  DATA_W  datapath result, valid LATENCY cycles after dp_issue.
REQ-012 SHALL have port out_valid  output  1  FIFO head valid.
REQ-013 SHALL have port out_ready  input  1  consumer pops head when high with out_valid.
REQ-014 SHALL have port out_data  output  DATA_W  FIFO head result; FP16 results zero-extended in bits [DATA_W-1:16].
REQ-015 SHALL have port out_mode  output  1  mode tag of FIFO head.
REQ-016 SHALL have port busy  output  1  high when any result is in flight or stored.

Function
REQ-017 SHALL compute accept = in_valid & in_ready; dp_issue = accept (combinational).
REQ-018 SHALL track inflight (0..LATENCY) with a LATENCY-deep valid/mode-tag shift register advanced every cycle.
REQ-019 SHALL write dp_result and its tag into the FIFO in the cycle the shift register output bit is 1; no write is ever dropped.
REQ-020 SHALL use credit flow: in_ready requires inflight + fifo_count < DEPTH, counted before this cycle's pop.
REQ-021 SHALL run FSM states RUN, DRAIN, SWITCH.
REQ-022 In RUN, in_ready = credit_ok & (in_mode == dp_mode); in_valid with in_mode != dp_mode moves to DRAIN with in_ready low.
REQ-023 In DRAIN, in_ready SHALL be 0; when inflight == 0 go to SWITCH (FIFO contents need not drain).
REQ-024 In SWITCH (exactly one cycle, in_ready 0), dp_mode SHALL load in_mode; next state RUN.
REQ-025 If in_valid drops in DRAIN, SHALL still complete DRAIN/SWITCH using the in_mode sampled on DRAIN entry.
REQ-026 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; pop with empty FIFO and push with full FIFO are impossible by construction and SHALL be asserted against.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 out_data/out_mode SHALL be registered FIFO head, out_valid = (fifo_count != 0).
REQ-029 Sustained throughput SHALL be one accept per cycle in RUN when out_ready is held high.
REQ-030 busy = (inflight != 0) | (fifo_count != 0).

Reset
REQ-031 On reset low, asynchronously: state RUN, dp_mode 0, shift register cleared, inflight 0, FIFO pointers/count 0, in_ready/dp_issue/out_valid/busy 0, out_data 0, out_mode 0.
REQ-032 Reset mid-operation SHALL discard all in-flight and stored results; first accept allowed on the first rising edge after reset deasserts.

Verification
REQ-033 Stream 20 FP16 sets, out_ready=1 -> first out_valid exactly 5 cycles after first accept, 20 results in order, one per cycle.
REQ-034 out_ready=0, in_valid=1 continuously -> exactly 8 accepts, then in_ready=0; FIFO holds 8; one pop re-enables one accept next cycle.
REQ-035 3 FP16 sets then FP32 set in next cycle -> FP32 accept stalls until inflight 0 plus one SWITCH cycle (first FP32 dp_issue 7 cycles after last FP16 accept), dp_mode=1, out_mode tags 0,0,0,1.
REQ-036 FIFO full (8) with out_ready toggling 1/0 while in_valid=1 -> no loss, no duplicate, pointer wrap after 8 entries verified by ordering.
REQ-037 reset asserted with 4 in flight and 3 stored -> all outputs 0 immediately, no stale out_valid after release.
REQ-038 Mode change request while FIFO nonempty and out_ready=0 -> switch completes without waiting for FIFO drain; tags preserved.

Source files
------------

// File: rtl/dp_pipe_ctrl.sv
// Issue and credit controller for a fixed-latency dot-product datapath.
// Tracks results in flight, buffers them in a result FIFO and switches FP16/FP32 mode through a drain.
module dp_pipe_ctrl #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mode,
  output logic              in_ready,
  output logic              dp_mode,
  output logic              dp_issue,
  input  logic [DATA_W-1:0] dp_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(DEPTH + LATENCY + 1);
  localparam logic [DATA_W-1:0] FP16_MASK = DATA_W'(17'h0FFFF);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              pend_mode;

  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] tag_sr;
  logic [IW-1:0]      inflight;
  logic [IW-1:0]      inflight_left;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic              mem_tag [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nxt;

  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              push_tag;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              drain_done;

  assign accept   = in_valid & in_ready;
  assign dp_issue = accept;

  assign push      = vld_sr[LATENCY-1];
  assign push_tag  = tag_sr[LATENCY-1];
  assign push_data = push_tag ? dp_result : (dp_result & FP16_MASK);

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (inflight != '0) | (fifo_count != '0);

  // Credits cover every result already issued, so the FIFO can never be asked to overflow.
  assign credit_ok = (SW'(inflight) + SW'(fifo_count)) < SW'(DEPTH);

  // The result leaving the shift register this cycle is already safe in the FIFO,
  // so the drain is finished once nothing else remains behind it.
  assign inflight_left = inflight - IW'(push);
  assign drain_done    = (inflight_left == '0);

  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign count_nxt  = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      pend_mode <= 1'b0;
      dp_mode   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && state_nxt == DRAIN)
        pend_mode <= in_mode;
      if (state == SWITCH)
        dp_mode <= pend_mode;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (in_valid && (in_mode != dp_mode)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = SWITCH;
      SWITCH:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (reset && state == RUN)
      in_ready = credit_ok && (in_mode == dp_mode);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr   <= '0;
      tag_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr   <= {vld_sr[LATENCY-2:0], accept};
      tag_sr   <= {tag_sr[LATENCY-2:0], dp_mode};
      inflight <= inflight_left + IW'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= push_data;
      mem_tag[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
    end
  end

  // Head register: a push landing in the next head slot bypasses the memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_mode <= 1'b0;
    end else if (count_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        out_data <= push_data;
        out_mode <= push_tag;
      end else begin
        out_data <= mem[rd_ptr_nxt];
        out_mode <= mem_tag[rd_ptr_nxt];
      end
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(pop && fifo_count == '0));

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_dp_pipe_ctrl.sv
// Self-checking bench for dp_pipe_ctrl: a cycle table for the FP16->FP32 switch,
// plus directed sequences for streaming, back-pressure, reset and switching with a full FIFO.
module tb_dp_pipe_ctrl;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic          in_ready;
  logic          dp_mode;
  logic          dp_issue;
  logic [DW-1:0] dp_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_mode;
  logic          busy;

  dp_pipe_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_mode(in_mode), .in_ready(in_ready),
    .dp_mode(dp_mode), .dp_issue(dp_issue), .dp_result(dp_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: the k-th issued set returns {D000+k, 5000+k} exactly LAT cycles later.
  logic [DW-1:0] pipe_q [LAT];
  int            n_issued;

  function automatic logic [31:0] expVal(input int k, input logic m);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'h5000 + k[15:0];
    hi = 16'hD000 + k[15:0];
    return m ? {hi, lo} : {16'h0000, lo};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_issued <= 0;
    end else begin
      if (dp_issue) n_issued <= n_issued + 1;
      pipe_q[0] <= dp_issue ? expVal(n_issued, 1'b1) : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign dp_result = pipe_q[LAT-1];

  typedef struct {
    logic vld, mode, ordy;
    logic e_rdy, e_dpm, e_ov, e_busy, e_omode;
    int   e_idx;
  } vec_t;

  typedef struct {
    logic mode;
    int   idx;
  } exp_t;

  vec_t       vecs [$];
  exp_t       exp_q [$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  int         pop_cnt = 0;
  logic       acc_now;
  logic       pop_now;
  logic [7:0] tag_hist;

  function automatic void addVec(input logic [7:0] b, input int idx);
    vec_t v;
    {v.vld, v.mode, v.ordy, v.e_rdy, v.e_dpm, v.e_ov, v.e_busy, v.e_omode} = b;
    v.e_idx = idx;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_mode   = m;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic scoreboardSample();
    exp_t e;
    acc_now = in_valid && in_ready;
    pop_now = out_valid && out_ready;
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL pop_unexpected: got a pop of 0x%08h, required no pop", out_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pop_data", out_data, expVal(e.idx, e.mode));
        checkOutput("pop_mode", 32'(out_mode), 32'(e.mode));
      end
      tag_hist = {tag_hist[6:0], out_mode};
      pop_cnt++;
    end
    if (acc_now) begin
      exp_q.push_back('{mode: in_mode, idx: acc_cnt});
      acc_cnt++;
    end
  endtask

  task automatic runCycle(input logic v, input logic m, input logic r);
    applyStimulus(v, m, r);
    scoreboardSample();
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    acc_cnt  = 0;
    pop_cnt  = 0;
    tag_hist = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_acc;
    int first_ov;
    int last_pop;
    int gap_bad;
    int sw_cyc;
    logic sw_ov;

    // {vld,mode,ordy, e_rdy,e_dpm,e_ov,e_busy,e_omode}, index of expected head result (-1: none)
    addVec(8'b101_10000, -1);
    addVec(8'b101_10010, -1);
    addVec(8'b101_10010, -1);
    addVec(8'b111_00010, -1);
    addVec(8'b111_00010, -1);
    addVec(8'b111_00010, -1);
    addVec(8'b111_00110,  0);
    addVec(8'b111_00110,  1);
    addVec(8'b111_00110,  2);
    addVec(8'b111_11000, -1);
    addVec(8'b011_11010, -1);
    addVec(8'b011_11010, -1);
    addVec(8'b011_11010, -1);
    addVec(8'b011_11010, -1);
    addVec(8'b011_11010, -1);
    addVec(8'b011_11111,  3);
    addVec(8'b011_11000, -1);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].vld, vecs[i].mode, vecs[i].ordy);
      checkOutput($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      checkOutput($sformatf("tbl%0d_dp_issue", i), 32'(dp_issue), 32'(vecs[i].vld & vecs[i].e_rdy));
      checkOutput($sformatf("tbl%0d_dp_mode", i), 32'(dp_mode), 32'(vecs[i].e_dpm));
      checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_idx >= 0) begin
        checkOutput($sformatf("tbl%0d_out_data", i), out_data, expVal(vecs[i].e_idx, vecs[i].e_omode));
        checkOutput($sformatf("tbl%0d_out_mode", i), 32'(out_mode), 32'(vecs[i].e_omode));
      end
    end

    // Reset with 4 in flight and 3 stored; the table above issued sets 0..3 in FP32 mode now.
    acc_cnt = 4;
    for (int c = 0; c < 9; c++) runCycle(c < 7, 1'b1, 1'b0);
    checkOutput("prerst_out_valid", 32'(out_valid), 32'd1);
    checkOutput("prerst_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_dp_issue", 32'(dp_issue), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_mode", 32'(out_mode), 32'd0);
    checkOutput("rst_dp_mode", 32'(dp_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    #1;
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
    scoreboardSample();
    for (int c = 0; c < 12; c++) runCycle(1'b0, 1'b0, 1'b1);
    checkOutput("postrst_pops", 32'(pop_cnt), 32'd1);

    // Stream 20 FP16 sets with the consumer always ready.
    doReset();
    first_acc = -1;
    first_ov  = -1;
    last_pop  = -1;
    gap_bad   = 0;
    for (int c = 0; c < 40; c++) begin
      runCycle(c < 20, 1'b0, 1'b1);
      if (acc_now && first_acc < 0) first_acc = c;
      if (out_valid && first_ov < 0) first_ov = c;
      if (pop_now) begin
        if (last_pop >= 0 && c != last_pop + 1) gap_bad++;
        last_pop = c;
      end
    end
    // out_valid rises on the LAT-th edge after the accepting edge, i.e. in cycle accept+LAT+1.
    checkOutput("stream_first_ov", 32'(first_ov - first_acc), 32'(LAT + 1));
    checkOutput("stream_accepts", 32'(acc_cnt), 32'd20);
    checkOutput("stream_pops", 32'(pop_cnt), 32'd20);
    checkOutput("stream_gaps", 32'(gap_bad), 32'd0);

    // Back-pressure: fill to DEPTH, single pop frees a single credit, then toggle the consumer.
    doReset();
    for (int c = 0; c < 14; c++) runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("fill_accepts", 32'(acc_cnt), 32'(DEPTH));
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    checkOutput("fill_out_valid", 32'(out_valid), 32'd1);
    runCycle(1'b1, 1'b0, 1'b1);
    checkOutput("popcyc_in_ready", 32'(in_ready), 32'd0);
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("refill_in_ready", 32'(in_ready), 32'd1);
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("refull_in_ready", 32'(in_ready), 32'd0);
    checkOutput("refill_accepts", 32'(acc_cnt), 32'(DEPTH + 1));
    for (int c = 0; c < 40; c++) runCycle(1'b1, 1'b0, (c % 2) == 0);
    for (int c = 0; c < 30; c++) runCycle(1'b0, 1'b0, 1'b1);
    checkOutput("wrap_pops_eq_accepts", 32'(pop_cnt), 32'(acc_cnt));
    checkOutput("wrap_busy", 32'(busy), 32'd0);

    // Mode change with results parked in the FIFO and the consumer stalled.
    doReset();
    sw_cyc = -1;
    sw_ov  = 1'b0;
    for (int c = 0; c < 3; c++) runCycle(1'b1, 1'b0, 1'b0);
    for (int c = 3; c < 23 && sw_cyc < 0; c++) begin
      runCycle(1'b1, 1'b1, 1'b0);
      if (acc_now) begin
        sw_cyc = c;
        sw_ov  = out_valid;
      end
    end
    checkOutput("switch_accept_cycle", 32'(sw_cyc), 32'd9);
    checkOutput("switch_fifo_nonempty", 32'(sw_ov), 32'd1);
    checkOutput("switch_dp_mode", 32'(dp_mode), 32'd1);
    runCycle(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) runCycle(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) runCycle(1'b0, 1'b1, 1'b1);
    checkOutput("switch_pops", 32'(pop_cnt), 32'd5);
    checkOutput("switch_tags", 32'(tag_hist[4:0]), 32'(5'b00011));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
